fetch_stage_queue: RTL and testbench



---
 rtl/fetch_stage_queue.sv | 96 +++++++++
 tb/tb_fetch_stage_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_queue.sv
// rtl/fetch_stage_queue.sv - instruction fetch PC plus small FIFO toward decode
// Fetched words are queued with their PC+4 and drained through a valid/ready handshake.
module fetch_stage_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   link_q  [DEPTH];

    logic        pop;
    logic        push;
    logic [31:0] pc_plus4;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^branch_addr[1:0];
    assign pc_plus4         = pc_q + 32'd4;

    assign pop  = (count_q != '0) & out_ready;
    assign push = !branch_taken & ((count_q < CW'(DEPTH)) | pop);

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (branch_taken) begin
            pc_d    = {branch_addr[31:2], 2'b00};
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) begin
                pc_d   = pc_plus4;
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // When full with a pop, tail equals head: the old head leaves as the new word lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                link_q[i]  <= '0;
            end
        end else if (push) begin
            instr_q[tail_q] <= imem_instr;
            link_q[tail_q]  <= pc_plus4;
        end
    end

    assign imem_addr  = pc_q;
    assign out_valid  = (count_q != '0);
    assign out_instr  = instr_q[head_q];
    assign out_pc     = link_q[head_q];
    assign fifo_count = count_q;

endmodule

// File: tb/tb_fetch_stage_queue.sv
// tb/tb_fetch_stage_queue.sv - scoreboard bench for fetch_stage_queue
module tb_fetch_stage_queue;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q [$];
    logic [63:0] mon_e;

    fetch_stage_queue #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .fifo_count   (fifo_count)
    );

    // Memory model: word at address a is a + 0x100.
    assign imem_instr = imem_addr + 32'h100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        out_ready    = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_transfer actual=%h/%h expected=none", out_instr, out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("xfer_instr", out_instr, mon_e[63:32]);
                check("xfer_pc", out_pc, mon_e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        out_ready    = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;

        // Reset state and streaming with decode always ready
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        exp_q.push_back({32'h100, 32'h4});
        exp_q.push_back({32'h104, 32'h8});
        exp_q.push_back({32'h108, 32'hC});
        out_ready = 1'b1;
        tick();
        check("t1_valid_first", 32'(out_valid), 32'd1);
        tick();
        check("t1_valid_steady", 32'(out_valid), 32'd1);
        tick();
        tick();
        check("t1_addr", imem_addr, 32'h10);
        out_ready = 1'b0;

        // Stall fills FIFO, then full-FIFO throughput with push and pop together
        do_reset();
        tick();
        check("t2_count1", 32'(fifo_count), 32'd1);
        tick();
        tick();
        check("t2_count_sat", 32'(fifo_count), 32'd2);
        check("t2_addr_stuck", imem_addr, 32'h8);
        exp_q.push_back({32'h100, 32'h4});
        exp_q.push_back({32'h104, 32'h8});
        exp_q.push_back({32'h108, 32'hC});
        out_ready = 1'b1;
        tick();
        check("t3_count_a", 32'(fifo_count), 32'd2);
        check("t3_addr_a", imem_addr, 32'hC);
        tick();
        check("t3_count_b", 32'(fifo_count), 32'd2);
        check("t3_addr_b", imem_addr, 32'h10);
        tick();
        out_ready = 1'b0;
        check("t3_addr_c", imem_addr, 32'h14);

        // Branch with two entries queued, unaligned target
        branch_taken = 1'b1;
        branch_addr  = 32'h93;
        tick();
        branch_taken = 1'b0;
        check("t4_count", 32'(fifo_count), 32'd0);
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_addr", imem_addr, 32'h90);
        tick();
        check("t4_head_valid", 32'(out_valid), 32'd1);
        check("t4_head_instr", out_instr, 32'h190);
        check("t4_head_pc", out_pc, 32'h94);
        tick();
        check("t4_full", 32'(fifo_count), 32'd2);

        // Reset wins over a simultaneous branch
        rst          = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        tick();
        rst          = 1'b0;
        branch_taken = 1'b0;
        check("t5_addr", imem_addr, 32'h0);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_instr", out_instr, 32'h0);

        // PC wrap across the top of the address space
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFF8;
        exp_q.push_back({32'h0000_00F8, 32'hFFFF_FFFC});
        exp_q.push_back({32'h0000_00FC, 32'h0000_0000});
        out_ready = 1'b1;
        tick();
        branch_taken = 1'b0;
        check("t6_addr_target", imem_addr, 32'hFFFF_FFF8);
        check("t6_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        tick();
        check("t6_addr_wrap", imem_addr, 32'h4);
        out_ready = 1'b0;
        tick();
        tick();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
